fetch_stage: RTL

- Instruction-fetch stage directly upstream of the main decoder.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Presents one registered instruction per handshake to decode; id_op feeds the decoder's op input.
- Handles decode back-pressure, branch redirect and squashing of in-flight fetches; empty slots are presented as the all-zero bubble opcode.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch/decode types: XLEN, opcode constants, fetch FSM states, PC step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int PC_STEP = 4;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BUBBLE = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory req/ack port, branch redirect, decode slot.
// Latency: n/a (wires only).
// Backpressure: decode stalls via id_ready; memory stalls by withholding imem_ack.
interface fetch_stage_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [6:0]      id_op;

    // The fetch stage itself.
    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_op,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    // Memory, branch unit and decoder seen from the other side.
    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_op,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+PC parking slot used when decode is stalled at ack time.
// Latency: load visible on the next clock; unload/clear empty it on the next clock.
// Backpressure: none internally; the owner only loads when the entry is empty.
module fetch_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            vld,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    // Clear/unload win over load so a squash never leaves a stale entry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (clear || unload) begin
            vld <= 1'b0;
        end else if (load) begin
            vld       <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem req/ack, presents one registered instr to decode.
// Latency: id_* valid one clock after imem_ack; redirect squashes in-flight and presented work.
// Backpressure: id_ready=0 parks one response in a skid entry and drops imem_req; optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall,
    output logic [15:0]  perf_squash
`endif
);
    import riscv_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_q;
    logic            req_q;
    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] ipc_q;

    logic [XLEN-1:0] pc_inc;
    logic            slot_free;
    logic            skid_load;
    logic            skid_unload;
    logic            skid_clear;
    logic            skid_vld;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;

    assign pc_inc    = pc_q + XLEN'(PC_STEP);
    assign slot_free = !valid_q || bus.id_ready;

    // Park only when decode cannot take the response; a redirect always empties the entry.
    assign skid_load   = (state == REQ) && bus.imem_ack && !bus.redirect_valid && !slot_free;
    assign skid_unload = (state == HOLD) && bus.id_ready && !bus.redirect_valid;
    assign skid_clear  = bus.redirect_valid;

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .in_instr  (bus.imem_rdata),
        .in_pc     (pc_q),
        .vld       (skid_vld),
        .out_instr (skid_instr),
        .out_pc    (skid_pc)
    );

    // Fetch FSM with registered request/address and decode-slot outputs; redirect has top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else if (bus.redirect_valid) begin
            valid_q <= 1'b0;
            pc_q    <= bus.redirect_pc;
            case (state)
                REQ, DROP: begin
                    req_q <= 1'b1;
                    if (bus.imem_ack) begin
                        // Response in this cycle belongs to the old path: discard it.
                        state  <= REQ;
                        addr_q <= bus.redirect_pc;
                    end else begin
                        // Memory still owes a response at the old address; keep it stable.
                        state <= DROP;
                    end
                end
                default: begin
                    state  <= REQ;
                    req_q  <= 1'b1;
                    addr_q <= bus.redirect_pc;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    state  <= REQ;
                    req_q  <= 1'b1;
                    addr_q <= pc_q;
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        pc_q   <= pc_inc;
                        addr_q <= pc_inc;
                        if (slot_free) begin
                            valid_q <= 1'b1;
                            instr_q <= bus.imem_rdata;
                            ipc_q   <= pc_q;
                        end else begin
                            state <= HOLD;
                            req_q <= 1'b0;
                        end
                    end else if (bus.id_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (bus.id_ready && skid_vld) begin
                        valid_q <= 1'b1;
                        instr_q <= skid_instr;
                        ipc_q   <= skid_pc;
                        state   <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        state  <= REQ;
                        addr_q <= pc_q;
                    end
                    if (bus.id_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.id_valid  = valid_q;
    assign bus.id_instr  = instr_q;
    assign bus.id_pc     = ipc_q;
    assign bus.id_op     = valid_q ? instr_q[6:0] : OP_BUBBLE;

`ifdef FETCH_PERF_CNT_EN
    logic fetched_evt;
    logic squash_evt;
    logic stall_evt;

    assign fetched_evt = bus.imem_ack && (state == REQ) && !bus.redirect_valid;
    assign squash_evt  = bus.imem_ack && ((state == DROP) || ((state == REQ) && bus.redirect_valid));
    assign stall_evt   = valid_q && !bus.id_ready;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_squash  <= '0;
        end else begin
            if (fetched_evt && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            if (stall_evt && (perf_stall != '1))     perf_stall   <= perf_stall + 32'd1;
            if (squash_evt && (perf_squash != '1))   perf_squash  <= perf_squash + 16'd1;
        end
    end
`endif

endmodule
